// File: rtl/path_delay_meter.sv
// Launch/capture controller for a chained spy path: fires one edge into the path and counts
// clk cycles until the synchronised path result reaches the expected level.
module path_delay_meter #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned MAX_CYCLES    = 1000,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter bit          INVERT        = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] delayCount,
  output logic             edgeRising,
  output logic             pathInput,
  input  logic             pathResult
);

  typedef enum logic [1:0] {StIdle, StSettle, StLaunch, StWait} state_e;

  // A direct wire loopback matches after SYNC_STAGES wait cycles; it must report 1.
  localparam logic [CNT_W-1:0] Offset     = CNT_W'(SYNC_STAGES - 1);
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MaxCnt     = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] One        = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             rising_q, rising_d;
  logic             pin_q, pin_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             s_res;
  logic             match;

  assign s_res = sync_q[SYNC_STAGES-1];
  assign match = (s_res == (pin_q ^ INVERT));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StSettle;
      StSettle: if (cnt_q == SettleLast) state_d = StLaunch;
      StLaunch: state_d = StWait;
      StWait:   if (match || (cnt_q == MaxCnt)) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    cnt_d     = cnt_q;
    delay_d   = delay_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    rising_d  = rising_q;
    pin_d     = pin_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          busy_d    = 1'b1;
          timeout_d = 1'b0;
          cnt_d     = '0;
        end
      end
      StSettle: cnt_d = cnt_q + One;
      StLaunch: begin
        pin_d    = ~pin_q;
        rising_d = ~pin_q;
        cnt_d    = '0;
      end
      StWait: begin
        cnt_d = cnt_q + One;
        if (match) begin
          delay_d = (cnt_q > Offset) ? (cnt_q - Offset) : One;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (cnt_q == MaxCnt) begin
          timeout_d = 1'b1;
          delay_d   = '1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      delay_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      rising_q  <= 1'b0;
      pin_q     <= 1'b0;
      sync_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      delay_q   <= delay_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      rising_q  <= rising_d;
      pin_q     <= pin_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pathResult};
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign delayCount = delay_q;
  assign edgeRising = rising_q;
  assign pathInput  = pin_q;

endmodule
